beam_scaler_bank: RTL and testbench



---
 rtl/beam_scaler_bank.sv | 133 +++++++++++++
 tb/tb_beam_scaler_bank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_scaler_bank.sv
// Double-buffered per-beam trigger/subthreshold rate scaler with a Wishbone-classic read port.
// Define SCALER_SATURATE_EN to make counters saturate at full scale instead of wrapping.
module beam_scaler_bank #(
   parameter int NBEAMS     = 2,
   parameter int COUNT_BITS = 16
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [11:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   input  logic [3:0]            wb_sel_i,
   output logic                  wb_ack_o,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_err_o,
   output logic                  wb_rty_o,
   input  logic [2*NBEAMS-1:0]   count_i,
   input  logic                  timer_i,
   input  logic                  rst_i,
   output logic                  done_o,
   output logic                  bank_o
);

   localparam int         NCNT     = 2 * NBEAMS;
   localparam logic [9:0] STATUS_W = 10'h3FF;

   logic [COUNT_BITS-1:0] cnt_q  [NCNT];
   logic [COUNT_BITS-1:0] cnt_d  [NCNT];
   logic [COUNT_BITS-1:0] hold_q [NCNT];
   logic [COUNT_BITS-1:0] hold_d [NCNT];
   logic                  bank_q, bank_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  ack_q, ack_d;
   logic [31:0]           dat_q, dat_d;
   logic [31:0]           rd_data;
   logic [9:0]            word;
   logic                  unused_bits;

   // One-hit advance of a scaler; full-scale behaviour depends on the build option.
   function automatic logic [COUNT_BITS-1:0] bump(input logic [COUNT_BITS-1:0] c,
                                                  input logic hit);
`ifdef SCALER_SATURATE_EN
      if (hit && (c != {COUNT_BITS{1'b1}}))
         bump = c + 1'b1;
      else
         bump = c;
`else
      bump = c + {{(COUNT_BITS-1){1'b0}}, hit};
`endif
   endfunction

   always_comb begin
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      bank_d  = bank_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      if (timer_i) begin
         // The hit arriving with the timer pulse still belongs to the closing period.
         for (int k = 0; k < NCNT; k++) begin
            hold_d[k] = bump(cnt_q[k], count_i[k]);
            cnt_d[k]  = '0;
         end
         bank_d  = ~bank_q;
         valid_d = 1'b1;
         done_d  = 1'b1;
      end else begin
         for (int k = 0; k < NCNT; k++) begin
            cnt_d[k] = bump(cnt_q[k], count_i[k]);
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || rst_i) begin
         for (int k = 0; k < NCNT; k++) begin
            cnt_q[k]  <= '0;
            hold_q[k] <= '0;
         end
         bank_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         bank_q  <= bank_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      word    = wb_adr_i[11:2];
      rd_data = '0;
      for (int b = 0; b < NBEAMS; b++) begin
         if (word == 10'(b))
            rd_data = {hold_q[NBEAMS+b], hold_q[b]};
      end
      if (word == STATUS_W)
         rd_data = {30'b0, valid_q, bank_q};
   end

   // Ack drops for a cycle after every acknowledge, so a held strobe acks every other cycle.
   always_comb begin
      ack_d = wb_cyc_i & wb_stb_i & ~ack_q;
      dat_d = dat_q;
      if (ack_d && !wb_we_i)
         dat_d = rd_data;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
      end
   end

   assign unused_bits = ^{wb_dat_i, wb_sel_i, wb_adr_i[1:0]};

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign wb_err_o = 1'b0;
   assign wb_rty_o = 1'b0;
   assign done_o   = done_q;
   assign bank_o   = bank_q;

endmodule

// File: tb/tb_beam_scaler_bank.sv
// Scoreboard bench for beam_scaler_bank: directed test-plan scenarios followed by random traffic.
module tb_beam_scaler_bank;

   localparam int N = 2;

   logic           clk;
   logic           wb_rst_i, wb_cyc_i, wb_stb_i, wb_we_i;
   logic [11:0]    wb_adr_i;
   logic [31:0]    wb_dat_i;
   logic [3:0]     wb_sel_i;
   logic           wb_ack_o, wb_err_o, wb_rty_o;
   logic [31:0]    wb_dat_o;
   logic [2*N-1:0] count_i;
   logic           timer_i, rst_i, done_o, bank_o;

   beam_scaler_bank #(.NBEAMS(N), .COUNT_BITS(16)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
      .count_i(count_i), .timer_i(timer_i), .rst_i(rst_i), .done_o(done_o), .bank_o(bank_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit armed  = 0;

   typedef struct { bit wr; logic [31:0] d; } exp_t;
   exp_t exp_q[$];

   // Reference model: plain integer counts following the period rules.
   int m_cnt  [2*N];
   int m_hold [2*N];
   bit m_bank, m_valid, m_done, m_ack;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic int upd(input int x);
`ifdef SCALER_SATURATE_EN
      return (x > 65535) ? 65535 : x;
`else
      return x % 65536;
`endif
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      int w;
      w = int'(a[11:2]);
      if (w < N)
         return {16'(m_hold[N+w]), 16'(m_hold[w])};
      else if (w == 1023)
         return {30'b0, m_valid, m_bank};
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      bit   nack;
      exp_t e;
      if (wb_rst_i) begin
         m_ack = 1'b0;
         exp_q.delete();
      end else begin
         nack = wb_cyc_i && wb_stb_i && !m_ack;
         if (nack) begin
            e.wr = wb_we_i;
            e.d  = wb_we_i ? 32'h0 : model_read(wb_adr_i);
            exp_q.push_back(e);
         end
         m_ack = nack;
      end
      if (wb_rst_i || rst_i) begin
         for (int k = 0; k < 2*N; k++) begin
            m_cnt[k]  = 0;
            m_hold[k] = 0;
         end
         m_bank = 0; m_valid = 0; m_done = 0;
      end else if (timer_i) begin
         for (int k = 0; k < 2*N; k++) begin
            m_hold[k] = upd(m_cnt[k] + int'(count_i[k]));
            m_cnt[k]  = 0;
         end
         m_bank = !m_bank; m_valid = 1; m_done = 1;
      end else begin
         for (int k = 0; k < 2*N; k++)
            m_cnt[k] = upd(m_cnt[k] + int'(count_i[k]));
         m_done = 0;
      end
   end

   // Monitor: compares registered outputs and pops the scoreboard on every ack.
   always @(negedge clk) begin
      exp_t e;
      if (armed) begin
         chk("ack", {31'b0, wb_ack_o}, {31'b0, m_ack});
         chk("done", {31'b0, done_o}, {31'b0, m_done});
         chk("bank", {31'b0, bank_o}, {31'b0, m_bank});
         chk("err_rty", {30'b0, wb_err_o, wb_rty_o}, 32'h0);
         if (wb_ack_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 32'h1, 32'h0);
            end else begin
               e = exp_q.pop_front();
               if (!e.wr)
                  chk("rd_data", wb_dat_o, e.d);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wb_rst_i = 1'b1;
      tick();
      tick();
      wb_rst_i = 1'b0;
   endtask

   task automatic do_read(input logic [11:0] a, output logic [31:0] d);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
      tick();
      chk("read_acked", {31'b0, wb_ack_o}, 32'h1);
      d = wb_dat_o;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] d;
      logic [3:0]  pat;
      int          w;
      wb_rst_i = 1'b1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
      count_i = '0; timer_i = 0; rst_i = 0;

      // Reset / idle
      tick();
      armed = 1;
      tick();
      wb_rst_i = 1'b0;
      chk("rst_done", {31'b0, done_o}, 32'h0);
      chk("rst_bank", {31'b0, bank_o}, 32'h0);
      chk("rst_ack", {31'b0, wb_ack_o}, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
      do_read(12'hFFC, d); chk("rst_status", d, 32'h0);
      do_read(12'h000, d); chk("rst_word0", d, 32'h0);

      // Basic period
      do_reset();
      for (int i = 0; i < 10; i++) begin
         count_i = '0;
         count_i[0] = 1'b1;
         if (i < 3) count_i[N] = 1'b1;
         tick();
      end
      count_i = '0; timer_i = 1'b1;
      tick();
      timer_i = 1'b0;
      chk("basic_done_hi", {31'b0, done_o}, 32'h1);
      tick();
      chk("basic_done_lo", {31'b0, done_o}, 32'h0);
      do_read(12'h000, d); chk("basic_word0", d, 32'h0003000A);
      do_read(12'hFFC, d); chk("basic_status", d, 32'h00000003);

      // Boundary hit
      do_reset();
      count_i = '0; count_i[1] = 1'b1; timer_i = 1'b1;
      tick();
      timer_i = 1'b0;
      do_read(12'h004, d); chk("bound_word1_p1", d, 32'h00000001);
      tick();
      tick();
      count_i = '0; timer_i = 1'b1;
      tick();
      timer_i = 1'b0;
      do_read(12'h004, d); chk("bound_word1_p2", d, 32'h00000004);
      chk("bound_bank", {31'b0, bank_o}, 32'h0);

      // Overflow
      do_reset();
      count_i = '0; count_i[0] = 1'b1;
      for (int i = 0; i < 65540; i++) tick();
      count_i = '0; timer_i = 1'b1;
      tick();
      timer_i = 1'b0;
      do_read(12'h000, d);
`ifdef SCALER_SATURATE_EN
      chk("overflow_word0", d, 32'h0000FFFF);
`else
      chk("overflow_word0", d, 32'h00000004);
`endif

      // rst_i mid-period with a concurrent read
      do_reset();
      count_i = '0; count_i[0] = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      count_i = '0; rst_i = 1'b1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'h000;
      tick();
      chk("rsti_read_ack", {31'b0, wb_ack_o}, 32'h1);
      rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      count_i[0] = 1'b1;
      tick();
      tick();
      count_i = '0; timer_i = 1'b1;
      tick();
      timer_i = 1'b0;
      do_read(12'h000, d); chk("rsti_word0", d, 32'h00000002);
      do_read(12'hFFC, d); chk("rsti_status", d, 32'h00000003);

      // Handshake: held strobe, unmapped word, write
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'h000;
      for (int i = 0; i < 4; i++) begin
         tick();
         pat[i] = wb_ack_o;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      chk("hold_stb_ack_pattern", {28'b0, pat}, 32'h5);
      tick();
      do_read(12'h008, d); chk("unmapped_word2", d, 32'h0);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 12'h000; wb_dat_i = 32'hFFFF_FFFF;
      tick();
      chk("write_ack", {31'b0, wb_ack_o}, 32'h1);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      tick();
      do_read(12'h000, d); chk("after_write_word0", d, 32'h00000002);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         count_i  = (2*N)'($urandom);
         timer_i  = ($urandom_range(0, 39) == 0);
         rst_i    = ($urandom_range(0, 299) == 0);
         wb_rst_i = ($urandom_range(0, 999) == 0);
         wb_cyc_i = ($urandom_range(0, 1) == 0);
         wb_stb_i = wb_cyc_i;
         wb_we_i  = ($urandom_range(0, 4) == 0);
         wb_dat_i = $urandom;
         case ($urandom_range(0, 4))
            0: w = 0;
            1: w = 1;
            2: w = N;
            3: w = 1023;
            default: w = $urandom_range(0, 1023);
         endcase
         wb_adr_i = {10'(w), 2'($urandom)};
         tick();
      end
      count_i = '0; timer_i = 0; rst_i = 0; wb_rst_i = 0;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      tick();
      tick();
      chk("scoreboard_drained", exp_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
